except_ctrl: RTL and testbench

EXCEPT_CTRL -- requirements
Module: except_ctrl

---
 rtl/except_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_except_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/except_ctrl.sv
// -----------------------------------------------------------------------------
// except_ctrl
// MEM-stage exception controller. Picks one exception code per accepted
// instruction by fixed priority, pulses it to CP0 together with a pipeline
// flush and redirect target, then blocks new events for a short drain window.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | accepting MEM-stage instructions
// FLUSH  | one-cycle flush pulse, outputs carry the captured exception
// DRAIN  | DRAIN_CYCLES cycles of ignored events while the pipeline refills
//
// Ports
//   clk, rst                 clock, async active-low reset
//   stall_i, inst_valid_i    MEM stage handshake
//   *_i event flags          MEM-stage exception/event flags
//   pc_i, mem_addr_i,
//   is_in_delayslot_i        MEM-stage instruction context
//   cp0_*_i                  current Status / Cause / EPC
//   wb_cp0_*_i               WB-stage CP0 write (bypassed)
//   except_type_o, pc_o,
//   mem_addr_o,
//   is_in_delayslot_o        one-cycle exception report to CP0
//   flush_o, new_pc_o        flush pulse and redirect target
//   busy_o                   controller in FLUSH or DRAIN
// -----------------------------------------------------------------------------
module except_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        inst_valid_i,
    input  logic        if_adel_i,
    input  logic        ri_i,
    input  logic        ov_i,
    input  logic        trap_i,
    input  logic        syscall_i,
    input  logic        break_i,
    input  logic        eret_i,
    input  logic        ld_adel_i,
    input  logic        st_ades_i,
    input  logic [31:0] pc_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic [31:0] except_type_o,
    output logic [31:0] pc_o,
    output logic [31:0] mem_addr_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        int_pend_q, int_pend_d;
    logic [31:0] except_type_q, except_type_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        ds_q, ds_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;

    logic [31:0] eff_status;
    logic [7:0]  eff_cause_ip;
    logic [31:0] eff_epc;
    logic [7:0]  code;
    logic        accept;
    logic        take;
    logic        unused_bits;

    // WB-stage CP0 writes land after this cycle, so bypass them here to see
    // the values the exception actually has to be judged against.
    always_comb begin
        eff_status   = cp0_status_i;
        eff_cause_ip = cp0_cause_i[15:8];
        eff_epc      = cp0_epc_i;
        if (wb_cp0_we_i) begin
            if (wb_cp0_waddr_i == 5'd12) eff_status        = wb_cp0_data_i;
            if (wb_cp0_waddr_i == 5'd13) eff_cause_ip[1:0] = wb_cp0_data_i[9:8];
            if (wb_cp0_waddr_i == 5'd14) eff_epc           = wb_cp0_data_i;
        end
        int_pend_d = (|(eff_status[15:8] & eff_cause_ip)) & eff_status[0] & ~eff_status[1];
    end

    assign unused_bits = ^{eff_status[31:16], eff_status[7:2],
                           cp0_cause_i[31:16], cp0_cause_i[7:0]};

    always_comb begin
        if      (int_pend_q) code = 8'h01;
        else if (if_adel_i)  code = 8'h0f;
        else if (ri_i)       code = 8'h0a;
        else if (ov_i)       code = 8'h0c;
        else if (trap_i)     code = 8'h0d;
        else if (syscall_i)  code = 8'h08;
        else if (break_i)    code = 8'h09;
        else if (eret_i)     code = 8'h0e;
        else if (ld_adel_i)  code = 8'h04;
        else if (st_ades_i)  code = 8'h05;
        else                 code = 8'h00;
    end

    assign accept = (state_q == ST_IDLE) & inst_valid_i & ~stall_i;
    assign take   = accept & (code != 8'h00);

    // State register and datapath flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 4'd0;
            int_pend_q    <= 1'b0;
            except_type_q <= 32'd0;
            pc_q          <= 32'd0;
            mem_addr_q    <= 32'd0;
            ds_q          <= 1'b0;
            flush_q       <= 1'b0;
            new_pc_q      <= 32'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            int_pend_q    <= int_pend_d;
            except_type_q <= except_type_d;
            pc_q          <= pc_d;
            mem_addr_q    <= mem_addr_d;
            ds_q          <= ds_d;
            flush_q       <= flush_d;
            new_pc_q      <= new_pc_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (take) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                state_d = ST_DRAIN;
                cnt_d   = DRAIN_LOAD;
            end
            ST_DRAIN: begin
                // Terminal count at 1 so DRAIN lasts exactly DRAIN_LOAD cycles.
                if (cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output logic: report registers are loaded only on a taken exception,
    // so every report output is zero outside the one-cycle pulse.
    always_comb begin
        except_type_d = 32'd0;
        pc_d          = 32'd0;
        mem_addr_d    = 32'd0;
        ds_d          = 1'b0;
        flush_d       = 1'b0;
        new_pc_d      = 32'd0;
        if (take) begin
            except_type_d = {24'd0, code};
            pc_d          = pc_i;
            mem_addr_d    = mem_addr_i;
            ds_d          = is_in_delayslot_i;
            flush_d       = 1'b1;
            new_pc_d      = (code == 8'h0e) ? eff_epc : EXC_VECTOR;
        end
    end

    assign except_type_o     = except_type_q;
    assign pc_o              = pc_q;
    assign mem_addr_o        = mem_addr_q;
    assign is_in_delayslot_o = ds_q;
    assign flush_o           = flush_q;
    assign new_pc_o          = new_pc_q;
    assign busy_o            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_except_ctrl.sv
// -----------------------------------------------------------------------------
// tb_except_ctrl
// Directed scenarios followed by randomized traffic. Expected outputs come from
// a cycle-level reference: a "busy cycles remaining" counter, a priority table
// scan and the interrupt condition evaluated from the bypassed CP0 values.
// -----------------------------------------------------------------------------
module tb_except_ctrl;

    localparam logic [31:0] EXC_VEC = 32'hBFC00380;
    localparam int          DRAIN   = 2;
    localparam logic [7:0]  CODES [10] = '{8'h01, 8'h0f, 8'h0a, 8'h0c, 8'h0d,
                                           8'h08, 8'h09, 8'h0e, 8'h04, 8'h05};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i, inst_valid_i;
    logic        if_adel_i, ri_i, ov_i, trap_i, syscall_i, break_i, eret_i;
    logic        ld_adel_i, st_ades_i;
    logic [31:0] pc_i, mem_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_data_i;
    logic [31:0] except_type_o, pc_o, mem_addr_o, new_pc_o;
    logic        is_in_delayslot_o, flush_o, busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int          busy_left;
    logic        m_int_pend;
    logic [31:0] e_type, e_pc, e_addr, e_newpc;
    logic        e_ds, e_flush, e_busy;

    except_ctrl #(.EXC_VECTOR(EXC_VEC), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst(rst),
        .stall_i(stall_i), .inst_valid_i(inst_valid_i),
        .if_adel_i(if_adel_i), .ri_i(ri_i), .ov_i(ov_i), .trap_i(trap_i),
        .syscall_i(syscall_i), .break_i(break_i), .eret_i(eret_i),
        .ld_adel_i(ld_adel_i), .st_ades_i(st_ades_i),
        .pc_i(pc_i), .is_in_delayslot_i(is_in_delayslot_i), .mem_addr_i(mem_addr_i),
        .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
        .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i),
        .wb_cp0_data_i(wb_cp0_data_i),
        .except_type_o(except_type_o), .pc_o(pc_o), .mem_addr_o(mem_addr_o),
        .is_in_delayslot_o(is_in_delayslot_o), .flush_o(flush_o),
        .new_pc_o(new_pc_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic int_cond_now();
        logic [31:0] st;
        logic [7:0]  ip;
        st = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) ? wb_cp0_data_i : cp0_status_i;
        ip = cp0_cause_i[15:8];
        if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) ip[1:0] = wb_cp0_data_i[9:8];
        return (|(st[15:8] & ip)) && st[0] && !st[1];
    endfunction

    function automatic logic [31:0] epc_now();
        return (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) ? wb_cp0_data_i : cp0_epc_i;
    endfunction

    function automatic logic [7:0] pick_code();
        logic [9:0] fl;
        fl = {m_int_pend, if_adel_i, ri_i, ov_i, trap_i, syscall_i, break_i,
              eret_i, ld_adel_i, st_ades_i};
        for (int i = 0; i < 10; i++)
            if (fl[9-i]) return CODES[i];
        return 8'h00;
    endfunction

    task automatic model_reset();
        busy_left  = 0;
        m_int_pend = 1'b0;
        e_type = 0; e_pc = 0; e_addr = 0; e_newpc = 0;
        e_ds = 0; e_flush = 0; e_busy = 0;
    endtask

    // Advance the reference by one rising edge using the current inputs.
    task automatic model_step();
        logic       acc;
        logic [7:0] c;
        acc = (busy_left == 0) && inst_valid_i && !stall_i;
        c   = pick_code();
        e_type = 0; e_pc = 0; e_addr = 0; e_newpc = 0; e_ds = 0; e_flush = 0;
        if (busy_left > 0) busy_left--;
        if (acc && c != 8'h00) begin
            e_type    = {24'd0, c};
            e_pc      = pc_i;
            e_addr    = mem_addr_i;
            e_ds      = is_in_delayslot_i;
            e_flush   = 1'b1;
            e_newpc   = (c == 8'h0e) ? epc_now() : EXC_VEC;
            busy_left = 1 + DRAIN;
        end
        e_busy     = (busy_left > 0);
        m_int_pend = int_cond_now();
    endtask

    task automatic check_all(input string tag);
        check({tag, "_type"},  except_type_o,     e_type);
        check({tag, "_pc"},    pc_o,              e_pc);
        check({tag, "_addr"},  mem_addr_o,        e_addr);
        check({tag, "_ds"},    is_in_delayslot_o, e_ds);
        check({tag, "_flush"}, flush_o,           e_flush);
        check({tag, "_newpc"}, new_pc_o,          e_newpc);
        check({tag, "_busy"},  busy_o,            e_busy);
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        stall_i = 0; inst_valid_i = 0;
        if_adel_i = 0; ri_i = 0; ov_i = 0; trap_i = 0; syscall_i = 0;
        break_i = 0; eret_i = 0; ld_adel_i = 0; st_ades_i = 0;
        pc_i = 0; mem_addr_i = 0; is_in_delayslot_i = 0;
        cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0;
        wb_cp0_we_i = 0; wb_cp0_waddr_i = 0; wb_cp0_data_i = 0;
    endtask

    initial begin
        idle_inputs();
        model_reset();

        // reset state
        @(posedge clk);
        #1;
        check_all("rst");

        // syscall on the first edge after reset release
        rst = 1'b1;
        inst_valid_i = 1; syscall_i = 1; pc_i = 32'h80001000;
        mem_addr_i = 32'h1234_5678; is_in_delayslot_i = 1;
        step("sys");
        check("sys_code", except_type_o, 32'h08);
        check("sys_pc", pc_o, 32'h80001000);
        check("sys_vec", new_pc_o, 32'hBFC00380);
        idle_inputs();
        step("sys_d1");
        check("sys_busy1", busy_o, 1);
        step("sys_d2");
        check("sys_busy2", busy_o, 1);
        step("sys_d3");
        check("sys_busy3", busy_o, 0);

        // eret with EPC bypassed from WB
        inst_valid_i = 1; eret_i = 1; cp0_epc_i = 0;
        wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h80002000;
        step("eret");
        check("eret_code", except_type_o, 32'h0e);
        check("eret_npc", new_pc_o, 32'h80002000);
        idle_inputs();
        repeat (3) step("eret_d");

        // interrupt beats a simultaneous overflow
        cp0_status_i = 32'h0000FF01; cp0_cause_i = 32'h00008000;
        step("int_arm");
        inst_valid_i = 1; ov_i = 1;
        step("int");
        check("int_code", except_type_o, 32'h01);
        idle_inputs();
        step("int_d1");
        check("int_noflush", flush_o, 0);
        repeat (2) step("int_d");

        // ri followed by ov during drain
        inst_valid_i = 1; ri_i = 1;
        step("ri");
        check("ri_code", except_type_o, 32'h0a);
        ri_i = 0; ov_i = 1;
        step("ri_ov");
        check("ri_ov_none", except_type_o, 0);
        idle_inputs();
        step("ri_d2");
        step("ri_idle");
        check("ri_busy_end", busy_o, 0);

        // stalled break held for three cycles
        inst_valid_i = 1; break_i = 1; stall_i = 1;
        repeat (3) begin
            step("stall");
            check("stall_none", except_type_o, 0);
        end
        stall_i = 0;
        step("brk");
        check("brk_code", except_type_o, 32'h09);
        idle_inputs();

        // asynchronous reset while in FLUSH
        repeat (3) step("pre_r");
        inst_valid_i = 1; syscall_i = 1; pc_i = 32'hDEAD0000;
        step("r_flush");
        check("r_flush_on", flush_o, 1);
        idle_inputs();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        rst = 1'b1;
        step("rst_rel");

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            inst_valid_i = ($urandom_range(0, 9) < 8);
            stall_i      = ($urandom_range(0, 4) == 0);
            if_adel_i    = ($urandom_range(0, 11) == 0);
            ri_i         = ($urandom_range(0, 11) == 0);
            ov_i         = ($urandom_range(0, 11) == 0);
            trap_i       = ($urandom_range(0, 11) == 0);
            syscall_i    = ($urandom_range(0, 11) == 0);
            break_i      = ($urandom_range(0, 11) == 0);
            eret_i       = ($urandom_range(0, 11) == 0);
            ld_adel_i    = ($urandom_range(0, 11) == 0);
            st_ades_i    = ($urandom_range(0, 11) == 0);
            pc_i         = $urandom;
            mem_addr_i   = $urandom;
            is_in_delayslot_i = 1'($urandom_range(0, 1));
            cp0_status_i = $urandom;
            if ($urandom_range(0, 3) != 0) cp0_status_i[0] = 1'b0;
            cp0_cause_i  = $urandom;
            cp0_epc_i    = $urandom;
            wb_cp0_we_i  = 1'($urandom_range(0, 1));
            wb_cp0_waddr_i = 5'($urandom_range(11, 15));
            wb_cp0_data_i  = $urandom;
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
